product_accumulator: RTL and testbench

Block-accumulation stage directly downstream of the (A+B)*(C-D) pipelined arithmetic unit. It consumes that unit's 16-bit signed product stream and sums fixed-length blocks of N samples into a saturating ACC_W-bit signed total. Each completed block sum goes out on a single-entry ready/valid output register, and the stage applies backpressure upstream only when necessary.

---
 rtl/product_accumulator.sv | 93 +++++++++
 tb/tb_product_accumulator.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums fixed-length blocks of N signed samples into a saturating ACC_W-bit total
// and presents each block result on a single-entry ready/valid output register.
module product_accumulator #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24,
  parameter int N      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_sat
);

  localparam int CNT_W = $clog2(N);
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {EMPTY, PENDING} state_t;

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic        [CNT_W-1:0]   cnt;
  logic                      sat_sticky;

  logic signed [ACC_W:0]     sum;
  logic signed [ACC_W-1:0]   clamped;
  logic                      ovf;
  logic                      last;
  logic                      accept;
  logic                      load;
  logic                      xfer;

  // One guard bit is enough: the sample is narrower than the accumulator,
  // so overflow shows up as the two top bits of sum disagreeing.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-DATA_W){in_data[DATA_W-1]}}, in_data};
    ovf     = sum[ACC_W] ^ sum[ACC_W-1];
    clamped = sum[ACC_W-1:0];
    if (ovf) clamped = sum[ACC_W] ? MINV : MAXV;
  end

  assign last      = (cnt == CNT_W'(N-1));
  assign out_valid = (state == PENDING);
  assign in_ready  = !clear && !(last && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign load      = accept && last;
  assign xfer      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      cnt        <= '0;
      sat_sticky <= 1'b0;
      state      <= EMPTY;
      out_sum    <= '0;
      out_sat    <= 1'b0;
    end else begin
      if (clear) begin
        acc        <= '0;
        cnt        <= '0;
        sat_sticky <= 1'b0;
      end else if (accept) begin
        if (last) begin
          acc        <= '0;
          cnt        <= '0;
          sat_sticky <= 1'b0;
        end else begin
          acc        <= clamped;
          cnt        <= cnt + CNT_W'(1);
          sat_sticky <= sat_sticky | ovf;
        end
      end

      if (load) begin
        out_sum <= clamped;
        out_sat <= sat_sticky | ovf;
      end

      unique case (state)
        EMPTY:   if (load) state <= PENDING;
        PENDING: if (xfer && !load) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Drives a 24-bit and an 18-bit accumulator with identical stimulus and checks
// both against a block-fold reference model every cycle.
module tb_product_accumulator;

  localparam int NB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, clear, out_ready;
  logic [15:0] in_data;

  logic        in_ready_w, out_valid_w, out_sat_w;
  logic [23:0] out_sum_w;
  logic        in_ready_n, out_valid_n, out_sat_n;
  logic [17:0] out_sum_n;

  product_accumulator #(.DATA_W(16), .ACC_W(24), .N(NB)) u_wide (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_data(in_data), .clear(clear), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_sum(out_sum_w), .out_sat(out_sat_w)
  );

  product_accumulator #(.DATA_W(16), .ACC_W(18), .N(NB)) u_narrow (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_data(in_data), .clear(clear), .out_valid(out_valid_n),
    .out_ready(out_ready), .out_sum(out_sum_n), .out_sat(out_sat_n)
  );

  int     n_checks = 0;
  int     n_fail   = 0;

  int     blk[$];
  bit     m_pend;
  longint m_sum_w, m_sum_n;
  bit     m_sat_w, m_sat_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Saturating running sum of the samples of one block at the given width.
  function automatic void fold(input int w, output longint s, output bit sat);
    longint mx, mn;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -(longint'(1) <<< (w - 1));
    s   = 0;
    sat = 1'b0;
    foreach (blk[i]) begin
      s += blk[i];
      if (s > mx) begin s = mx; sat = 1'b1; end
      else if (s < mn) begin s = mn; sat = 1'b1; end
    end
  endfunction

  task automatic check_outs(input string tag);
    logic [23:0] ew;
    logic [17:0] en;
    ew = m_sum_w[23:0];
    en = m_sum_n[17:0];
    chk({tag, ".valid_w"}, 32'(out_valid_w), 32'(m_pend));
    chk({tag, ".valid_n"}, 32'(out_valid_n), 32'(m_pend));
    chk({tag, ".sum_w"},   32'(out_sum_w),   32'(ew));
    chk({tag, ".sum_n"},   32'(out_sum_n),   32'(en));
    chk({tag, ".sat_w"},   32'(out_sat_w),   32'(m_sat_w));
    chk({tag, ".sat_n"},   32'(out_sat_n),   32'(m_sat_n));
  endtask

  task automatic do_reset(input bit v, input bit ordy);
    rst = 1'b1; in_valid = v; in_data = 16'd99; clear = 1'b0; out_ready = ordy;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    blk.delete();
    m_pend = 1'b0; m_sum_w = 0; m_sum_n = 0; m_sat_w = 1'b0; m_sat_n = 1'b0;
    check_outs("reset");
    #1;
    chk("reset.in_ready_w", 32'(in_ready_w), 32'd1);
    chk("reset.in_ready_n", 32'(in_ready_n), 32'd1);
  endtask

  // One clock: drive, check in_ready, update model at the edge, check outputs.
  task automatic cycle(input bit v, input logic [15:0] d, input bit clr,
                       input bit ordy, output bit took);
    bit exp_rdy, load;
    in_valid = v; in_data = d; clear = clr; out_ready = ordy;
    #1;
    exp_rdy = !clr && !(blk.size() == NB - 1 && m_pend && !ordy);
    chk("in_ready_w", 32'(in_ready_w), 32'(exp_rdy));
    chk("in_ready_n", 32'(in_ready_n), 32'(exp_rdy));
    took = v && exp_rdy;
    @(posedge clk);
    load = 1'b0;
    if (clr) blk.delete();
    else if (took) begin
      blk.push_back(int'($signed(d)));
      if (blk.size() == NB) begin
        fold(24, m_sum_w, m_sat_w);
        fold(18, m_sum_n, m_sat_n);
        blk.delete();
        load = 1'b1;
      end
    end
    if (load) m_pend = 1'b1;
    else if (m_pend && ordy) m_pend = 1'b0;
    #1;
    check_outs("cycle");
  endtask

  task automatic feed(input int count, input logic [15:0] d, input bit ordy);
    bit took;
    for (int i = 0; i < count; i++) cycle(1'b1, d, 1'b0, ordy, took);
  endtask

  initial begin
    bit took;
    logic [15:0] d;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
    #2;
    do_reset(1'b0, 1'b0);

    // basic block
    feed(NB, 16'd1000, 1'b1);
    chk("basic.sum_w", 32'(out_sum_w), 32'd8000);
    chk("basic.valid", 32'(out_valid_w), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, took);
    chk("basic.drop", 32'(out_valid_w), 32'd0);

    // positive saturation then sticky cleared
    feed(NB, 16'sd32767, 1'b1);
    chk("possat.sum_n", 32'(out_sum_n), 32'h1ffff);
    chk("possat.sat_n", 32'(out_sat_n), 32'd1);
    feed(NB, 16'd1, 1'b1);
    chk("possat.next_sum_n", 32'(out_sum_n), 32'd8);
    chk("possat.next_sat_n", 32'(out_sat_n), 32'd0);

    // negative saturation
    feed(NB, 16'h8000, 1'b1);
    chk("negsat.sum_n", 32'(out_sum_n), 32'h20000);
    chk("negsat.sat_n", 32'(out_sat_n), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, took);

    // backpressure
    feed(2 * NB - 1, 16'd1, 1'b0);
    cycle(1'b1, 16'd1, 1'b0, 1'b0, took);
    chk("bp.stall", 32'(took), 32'd0);
    cycle(1'b1, 16'd1, 1'b0, 1'b1, took);
    chk("bp.release", 32'(took), 32'd1);
    chk("bp.sum_w", 32'(out_sum_w), 32'd8);
    chk("bp.valid", 32'(out_valid_w), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, took);

    // clear mid-block
    feed(3, 16'd50, 1'b1);
    cycle(1'b1, 16'd77, 1'b1, 1'b1, took);
    chk("clear.dropped", 32'(took), 32'd0);
    feed(NB, -16'sd5, 1'b1);
    chk("clear.sum_w", 32'(out_sum_w), 32'(24'hffffd8));
    chk("clear.sat_w", 32'(out_sat_w), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b1, took);

    // reset mid-operation with a pending result
    feed(NB, 16'd3, 1'b0);
    feed(5, 16'd4, 1'b0);
    do_reset(1'b1, 1'b1);
    feed(NB, 16'd2, 1'b1);
    chk("rst.sum_w", 32'(out_sum_w), 32'd16);
    cycle(1'b0, '0, 1'b0, 1'b1, took);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 0) d = ($urandom_range(0, 1) == 0) ? 16'h7ff0 : 16'h8010;
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) != 0, took);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
